note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Replay stage directly downstream of the note-record RAM. Records are written by the key recorder as {key[1:0], start_time[12:0], duration[12:0]}.
- On start, it walks record addresses 0..num_records-1 and re-times each note against its own 10 ms play clock.
- Drives a 2-bit note code to the tone generator and the VGA displayer.
- Asserts done when the song ends.

Parameters:
- ADDR_W, 13, record RAM address width.
- TIME_W, 13, width of start_time, duration and play_time (units of 10 ms).
- TICK_DIV, 500000, clock cycles per 10 ms tick (50 MHz); benches use 4.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin playback from address 0
- stop  in  1  one-cycle pulse; abort playback
- num_records  in  ADDR_W  number of valid records, sampled on start
- rd_addr  out  ADDR_W  RAM address
- rd_data  in  28  RAM q; valid exactly 1 cycle after rd_addr changes
- note  out  2  00 none, 01 do, 10 re, 11 mi
- busy  out  1  high from accepted start until IDLE
- done  out  1  one-cycle pulse at normal end of song
- play_time  out  TIME_W  elapsed 10 ms ticks since start

Behaviour:
- Reset (synchronous, active-high) forces the following, overriding every other input that cycle:
  - state=IDLE; rd_addr, note, busy, done, play_time, tick divider and duration counter = 0.
- Tick: divider counts 0..TICK_DIV-1 only while busy; tick pulses on wrap.
  - play_time increments on tick and saturates at 2^TIME_W-1.
- States: IDLE, FETCH, WAIT, WAIT_START, PLAY, NEXT, FINISH.
- IDLE: on start, latch num_records, clear play_time/divider, set rd_addr=0, busy=1.
  - If num_records==0, go to FINISH; otherwise go to FETCH.
- FETCH: go to WAIT (1 cycle, covers RAM latency).
- WAIT: capture rd_data into key_r/start_r/dur_r.
  - If key==00 or dur==0, go to NEXT (rest or empty record; never drives note).
  - Otherwise go to WAIT_START.
- WAIT_START: note=00.
  - When play_time >= start_r, go to PLAY, load dur_cnt=dur_r, note=key_r (next cycle).
  - A late record (start_r already passed) plays immediately with its full duration; it is not shortened.
- PLAY: note=key_r; dur_cnt decrements on each tick.
  - When dur_cnt reaches 0, note=00 and go to NEXT.
  - Note high time is dur_r ticks, within ±1 tick of divider phase.
- NEXT:
  - If rd_addr==num_r-1, go to FINISH.
  - Otherwise rd_addr+=1 and go to FETCH.
  - rd_addr never exceeds num_r-1, so there is no wrap.
- FINISH: done=1 for exactly one cycle, busy=0, note=00, go to IDLE. play_time holds its last value until the next start.
- stop (any non-IDLE state): next cycle state=IDLE, note=00, busy=0, no done pulse.
- Simultaneous events:
  - start and stop together in IDLE: stop wins, nothing starts.
  - start while busy is ignored.
- play_time saturation: a record with start_r equal to the max value still plays. Once play_time has saturated, duration counting uses the divider tick independently, so PLAY always terminates.
- All outputs are registered; note changes only on clock edges.

Decomposition:
- Shared package piano_pkg holds:
  - key codes KEY_NONE/DO/RE/MI;
  - record field positions (KEY_MSB=27, START 25:13, DUR 12:0);
  - the TICK_DIV default.
- One natural sub-module: tick_gen (enable-gated divider producing a 1-cycle tick, clear input). It is shared with time_counter in future refactors.
- The FSM and datapath stay in note_player.

Test Plan:
- Reset mid-PLAY (reset=1 for 1 cycle while note=01) -> next cycle note=00, busy=0, play_time=0, rd_addr=0, no done.
- TICK_DIV=4, records {01,2,3},{10,6,2}, num_records=2, start:
  - note=01 from play_time 2 for 3 ticks (12±4 cycles), then 00.
  - note=10 from play_time 6 for 2 ticks.
  - done pulses once; busy falls with done.
- Records {11,0,1},{00,1,5},{01,3,0},{10,3,1} -> rest and zero-duration records never drive note; only 11 then 10 appear; rd_addr visits 0..3; done once.
- Late record: {01,0,4} then {10,1,2} where record 0 overruns start 1 -> note 10 begins immediately after note 01 ends and lasts a full 2 ticks.
- num_records=0 start -> busy high exactly 1 cycle, done pulses once, note stays 00, rd_addr stays 0.
- stop pulse during WAIT_START of record 1, and start pulsed while busy -> busy drops next cycle, no done, note 00; the start while busy is ignored (rd_addr not reset).

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano note path: key codes, note-record layout,
// playback FSM states and the default 10 ms tick divider.
package piano_pkg;

    localparam logic [1:0] KEY_NONE = 2'b00;
    localparam logic [1:0] KEY_DO   = 2'b01;
    localparam logic [1:0] KEY_RE   = 2'b10;
    localparam logic [1:0] KEY_MI   = 2'b11;

    localparam int REC_W     = 28;
    localparam int KEY_MSB   = 27;
    localparam int KEY_LSB   = 26;
    localparam int START_MSB = 25;
    localparam int START_LSB = 13;
    localparam int DUR_MSB   = 12;
    localparam int DUR_LSB   = 0;

    // 50 MHz system clock, 10 ms per tick
    localparam int TICK_DIV_DEFAULT = 500000;

    typedef struct packed {
        logic [KEY_MSB:KEY_LSB]     key;
        logic [START_MSB:START_LSB] start;
        logic [DUR_MSB:DUR_LSB]     dur;
    } record_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WAIT_START,
        S_PLAY,
        S_NEXT,
        S_FINISH
    } state_t;

    function automatic record_t unpack_record(input logic [REC_W-1:0] q);
        return record_t'(q);
    endfunction

endpackage

// File: rtl/note_player_tick_gen.sv
// Enable-gated clock divider: counts 0..DIV-1 while enabled and produces a
// one-cycle tick on the wrap. clear restarts the phase from zero.
module tick_gen
    import piano_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && !clear && (count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_player.sv
// Replays note records from the record RAM, re-timing each note against a
// local 10 ms play clock and driving the 2-bit note code.
module note_player
    import piano_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int TIME_W   = 13,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] num_records,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [27:0]       rd_data,
    output logic [1:0]        note,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] play_time
);

    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] num_r, num_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [1:0]        key_r, key_n;
    logic [TIME_W-1:0] start_r, start_n;
    logic [TIME_W-1:0] dur_r, dur_n;
    logic [TIME_W-1:0] dur_cnt, dur_cnt_n;
    logic [TIME_W-1:0] play_time_n;
    logic [1:0]        note_n;
    logic              busy_n;
    logic              done_n;
    logic              div_clear;
    logic              tick;
    record_t           rec;

    assign rec = unpack_record(rd_data);

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .enable(busy),
        .clear (div_clear),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_n     = state;
        num_n       = num_r;
        rd_addr_n   = rd_addr;
        key_n       = key_r;
        start_n     = start_r;
        dur_n       = dur_r;
        dur_cnt_n   = dur_cnt;
        note_n      = note;
        busy_n      = busy;
        done_n      = 1'b0;
        div_clear   = 1'b0;
        play_time_n = play_time;

        if (tick && (play_time != TIME_MAX)) begin
            play_time_n = play_time + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    num_n       = num_records;
                    play_time_n = '0;
                    div_clear   = 1'b1;
                    rd_addr_n   = '0;
                    busy_n      = 1'b1;
                    note_n      = KEY_NONE;
                    state_n     = (num_records == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                key_n   = rec.key;
                start_n = TIME_W'(rec.start);
                dur_n   = TIME_W'(rec.dur);
                // Rests and empty records are skipped without touching note
                if ((rec.key == KEY_NONE) || (rec.dur == '0)) begin
                    state_n = S_NEXT;
                end else begin
                    state_n = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                note_n = KEY_NONE;
                if (play_time >= start_r) begin
                    state_n   = S_PLAY;
                    dur_cnt_n = dur_r;
                    note_n    = key_r;
                end
            end
            S_PLAY: begin
                note_n = key_r;
                if (tick) begin
                    if (dur_cnt <= TIME_W'(1)) begin
                        dur_cnt_n = '0;
                        note_n    = KEY_NONE;
                        state_n   = S_NEXT;
                    end else begin
                        dur_cnt_n = dur_cnt - 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (rd_addr == (num_r - ADDR_W'(1))) begin
                    state_n = S_FINISH;
                end else begin
                    rd_addr_n = rd_addr + 1'b1;
                    state_n   = S_FETCH;
                end
            end
            S_FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                note_n  = KEY_NONE;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort outranks everything except reset; it never produces done
        if (stop && (state != S_IDLE)) begin
            state_n = S_IDLE;
            note_n  = KEY_NONE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // overrides whatever the next-state logic computed for this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            num_r     <= '0;
            rd_addr   <= '0;
            key_r     <= KEY_NONE;
            start_r   <= '0;
            dur_r     <= '0;
            dur_cnt   <= '0;
            note      <= KEY_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            play_time <= '0;
        end else begin
            state     <= state_n;
            num_r     <= num_n;
            rd_addr   <= rd_addr_n;
            key_r     <= key_n;
            start_r   <= start_n;
            dur_r     <= dur_n;
            dur_cnt   <= dur_cnt_n;
            note      <= note_n;
            busy      <= busy_n;
            done      <= done_n;
            play_time <= play_time_n;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a 1-cycle-latency record RAM model and
// a note-segment monitor; TICK_DIV is 4 so one tick is 4 clock cycles.
module tb_note_player;

    localparam int ADDR_W = 13;
    localparam int TIME_W = 13;
    localparam int DIV    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] num_records;
    logic [ADDR_W-1:0] rd_addr;
    logic [27:0]       rd_data;
    logic [1:0]        note;
    logic              busy;
    logic              done;
    logic [TIME_W-1:0] play_time;

    note_player #(
        .ADDR_W  (ADDR_W),
        .TIME_W  (TIME_W),
        .TICK_DIV(DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .num_records(num_records),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .note       (note),
        .busy       (busy),
        .done       (done),
        .play_time  (play_time)
    );

    always #5 clock = ~clock;

    logic [27:0] mem [8];
    always @(posedge clock) rd_data <= mem[rd_addr[2:0]];

    // Monitor: each contiguous run of a non-zero note is one segment
    int         cyc = 0;
    int         seg_n = 0;
    int         seg_begin = 0;
    int         done_cnt = 0;
    logic [1:0] prev_note = 2'b00;
    logic [1:0] seg_key [64];
    int         seg_pt  [64];
    int         seg_len [64];

    always @(negedge clock) begin
        if (prev_note != 2'b00 && note != prev_note && seg_n < 64) begin
            seg_len[seg_n] = cyc - seg_begin;
            seg_n++;
        end
        if (note != 2'b00 && note != prev_note && seg_n < 64) begin
            seg_key[seg_n] = note;
            seg_pt[seg_n]  = int'(play_time);
            seg_begin      = cyc;
        end
        prev_note = note;
        if (done === 1'b1) done_cnt++;
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual < lo || actual > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    function automatic logic [27:0] mk_rec(input logic [1:0] k, input int st, input int d);
        return {k, st[12:0], d[12:0]};
    endfunction

    task automatic run_song(input int budget, output int busy_cycles,
                            output logic [7:0] mask, output bit timed_out);
        busy_cycles = 0;
        mask        = 8'h00;
        timed_out   = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b1) begin
                busy_cycles++;
                mask[rd_addr[2:0]] = 1'b1;
            end
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    typedef struct packed {
        logic [2:0]        num;
        logic [3:0][27:0]  rec;
        logic [1:0]        n_notes;
        logic [1:0][1:0]   key;
        logic [1:0][12:0]  pt;
        logic [1:0][12:0]  dur;
        logic [7:0]        mask;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int         base, dbase, bc, dn;
        logic [7:0] mk;
        bit         to;

        // Expected segments: key, play_time at note onset (+1 allowed), ticks held
        vecs[0]         = '0;
        vecs[0].num     = 3'd2;
        vecs[0].rec[0]  = mk_rec(2'b01, 2, 3);
        vecs[0].rec[1]  = mk_rec(2'b10, 6, 2);
        vecs[0].n_notes = 2'd2;
        vecs[0].key[0]  = 2'b01; vecs[0].pt[0] = 13'd2; vecs[0].dur[0] = 13'd3;
        vecs[0].key[1]  = 2'b10; vecs[0].pt[1] = 13'd6; vecs[0].dur[1] = 13'd2;
        vecs[0].mask    = 8'h03;

        vecs[1]         = '0;
        vecs[1].num     = 3'd4;
        vecs[1].rec[0]  = mk_rec(2'b11, 0, 1);
        vecs[1].rec[1]  = mk_rec(2'b00, 1, 5);
        vecs[1].rec[2]  = mk_rec(2'b01, 3, 0);
        vecs[1].rec[3]  = mk_rec(2'b10, 3, 1);
        vecs[1].n_notes = 2'd2;
        vecs[1].key[0]  = 2'b11; vecs[1].pt[0] = 13'd0; vecs[1].dur[0] = 13'd1;
        vecs[1].key[1]  = 2'b10; vecs[1].pt[1] = 13'd3; vecs[1].dur[1] = 13'd1;
        vecs[1].mask    = 8'h0F;

        // Late record: note 10 starts once note 01 ends (play_time 4), full 2 ticks
        vecs[2]         = '0;
        vecs[2].num     = 3'd2;
        vecs[2].rec[0]  = mk_rec(2'b01, 0, 4);
        vecs[2].rec[1]  = mk_rec(2'b10, 1, 2);
        vecs[2].n_notes = 2'd2;
        vecs[2].key[0]  = 2'b01; vecs[2].pt[0] = 13'd0; vecs[2].dur[0] = 13'd4;
        vecs[2].key[1]  = 2'b10; vecs[2].pt[1] = 13'd4; vecs[2].dur[1] = 13'd2;
        vecs[2].mask    = 8'h03;

        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        num_records = '0;
        repeat (3) @(negedge clock);
        check("reset_note", 32'(note), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_play_time", 32'(play_time), 0);
        check("reset_rd_addr", 32'(rd_addr), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Table-driven songs
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = vecs[v].rec[i];
            num_records = ADDR_W'(vecs[v].num);
            base  = seg_n;
            dbase = done_cnt;
            run_song(400, bc, mk, to);
            repeat (6) @(negedge clock);
            check($sformatf("v%0d_timeout", v), 32'(to), 0);
            check($sformatf("v%0d_done_count", v), 32'(done_cnt - dbase), 1);
            check($sformatf("v%0d_note_count", v), 32'(seg_n - base), 32'(vecs[v].n_notes));
            for (int i = 0; i < int'(vecs[v].n_notes); i++) begin
                if (seg_n - base > i) begin
                    check($sformatf("v%0d_n%0d_key", v, i), 32'(seg_key[base+i]), 32'(vecs[v].key[i]));
                    check_range($sformatf("v%0d_n%0d_onset", v, i), seg_pt[base+i],
                                int'(vecs[v].pt[i]), int'(vecs[v].pt[i]) + 1);
                    check_range($sformatf("v%0d_n%0d_cycles", v, i), seg_len[base+i],
                                DIV * int'(vecs[v].dur[i]) - DIV, DIV * int'(vecs[v].dur[i]) + DIV);
                end
            end
            check($sformatf("v%0d_addr_mask", v), 32'(mk), 32'(vecs[v].mask));
            check($sformatf("v%0d_busy_end", v), 32'(busy), 0);
            check($sformatf("v%0d_note_end", v), 32'(note), 0);
        end

        // Empty song: busy for one cycle, one done, no note
        num_records = '0;
        base  = seg_n;
        dbase = done_cnt;
        run_song(20, bc, mk, to);
        repeat (5) @(negedge clock);
        check("empty_timeout", 32'(to), 0);
        check("empty_busy_cycles", 32'(bc), 1);
        check("empty_addr_mask", 32'(mk), 1);
        check("empty_done_count", 32'(done_cnt - dbase), 1);
        check("empty_note_count", 32'(seg_n - base), 0);

        // Reset while a note is sounding
        mem[0] = mk_rec(2'b00, 0, 1);
        mem[1] = mk_rec(2'b01, 3, 8);
        num_records = ADDR_W'(2);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (note === 2'b01) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        check("midplay_reached", 32'(to), 0);
        dbase = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midplay_note", 32'(note), 0);
        check("midplay_busy", 32'(busy), 0);
        check("midplay_play_time", 32'(play_time), 0);
        check("midplay_rd_addr", 32'(rd_addr), 0);
        check("midplay_done", 32'(done), 0);
        repeat (10) @(negedge clock);
        check("midplay_no_done", 32'(done_cnt - dbase), 0);
        check("midplay_stays_idle", 32'(busy), 0);

        // Start while busy is ignored, then stop in WAIT_START of record 1
        mem[0] = mk_rec(2'b01, 0, 1);
        mem[1] = mk_rec(2'b10, 20, 2);
        num_records = ADDR_W'(2);
        dbase = done_cnt;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rd_addr == ADDR_W'(1)) begin
                to = 1'b0;
                break;
            end
            @(negedge clock);
        end
        check("stop_reached_rec1", 32'(to), 0);
        repeat (6) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_start_rd_addr", 32'(rd_addr), 1);
        check("busy_start_busy", 32'(busy), 1);
        check("wait_start_note", 32'(note), 0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_note", 32'(note), 0);
        repeat (10) @(negedge clock);
        check("stop_no_done", 32'(done_cnt - dbase), 0);

        // start and stop together in IDLE: nothing starts
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle_busy", 32'(busy), 0);
        repeat (4) @(negedge clock);
        check("start_stop_idle_later", 32'(busy), 0);

        // Record at the saturation value of play_time still plays and ends
        mem[0] = mk_rec(2'b01, 8191, 1);
        num_records = ADDR_W'(1);
        base  = seg_n;
        dbase = done_cnt;
        run_song(34000, bc, mk, to);
        repeat (4) @(negedge clock);
        check("sat_timeout", 32'(to), 0);
        check("sat_note_count", 32'(seg_n - base), 1);
        if (seg_n > base) begin
            check("sat_key", 32'(seg_key[base]), 1);
            check("sat_onset", 32'(seg_pt[base]), 8191);
        end
        check("sat_done_count", 32'(done_cnt - dbase), 1);
        check("sat_play_time_hold", 32'(play_time), 8191);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
